coin_sprite_ctrl: RTL and testbench

- Upstream stage of the coin animation frame selector: owns coin world state and drives the coin sprite ROMs.
- Holds NUM_COINS coin positions with per-coin active flags, detects player pickups once per frame, and respawns the set after a delay.
- Per pixel, produces the shared sprite ROM read address for all four animation-frame ROMs, plus an is_coin flag delayed to line up with the selected ROM data.

---
 rtl/coin_pkg.sv | 21 ++
 rtl/coin_box_hit.sv | 28 ++
 rtl/coin_sprite_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_coin_sprite_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin sprite controller: FSM states and the
// per-slot world record.
package coin_pkg;

    localparam int COIN_W_DEF = 16;
    localparam int COIN_H_DEF = 16;
    localparam int MAX_COINS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_RESPAWN
    } coin_state_t;

    typedef struct packed {
        logic [12:0] x;
        logic [12:0] y;
        logic        active;
    } coin_slot_t;

endpackage

// File: rtl/coin_box_hit.sv
// Strict overlap of two half-open boxes [x, x+w) x [y, y+h); a point test is a
// 1x1 box. Sums are 14 bits wide so a box at the right screen edge never wraps.
module coin_box_hit (
    input  logic [12:0] i_a_x,
    input  logic [12:0] i_a_y,
    input  logic [13:0] i_a_w,
    input  logic [13:0] i_a_h,
    input  logic [12:0] i_b_x,
    input  logic [12:0] i_b_y,
    input  logic [13:0] i_b_w,
    input  logic [13:0] i_b_h,
    output logic        o_hit
);

    logic [13:0] w_a_x;
    logic [13:0] w_a_y;
    logic [13:0] w_b_x;
    logic [13:0] w_b_y;

    assign w_a_x = {1'b0, i_a_x};
    assign w_a_y = {1'b0, i_a_y};
    assign w_b_x = {1'b0, i_b_x};
    assign w_b_y = {1'b0, i_b_y};

    assign o_hit = (w_a_x < w_b_x + i_b_w) && (w_b_x < w_a_x + i_a_w) &&
                   (w_a_y < w_b_y + i_b_h) && (w_b_y < w_a_y + i_a_h);

endmodule

// File: rtl/coin_sprite_ctrl.sv
// Coin world state: slot storage, per-pixel sprite ROM addressing, a once-per-frame
// pickup scan, and delayed respawn of the whole coin set.
module coin_sprite_ctrl
    import coin_pkg::*;
#(
    parameter int NUM_COINS      = 4,
    parameter int COIN_W         = COIN_W_DEF,
    parameter int COIN_H         = COIN_H_DEF,
    parameter int ADDR_W         = 8,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic [12:0]       DrawX,
    input  logic [12:0]       DrawY,
    input  logic              load_valid,
    input  logic [2:0]        load_idx,
    input  logic [12:0]       load_x,
    input  logic [12:0]       load_y,
    input  logic [12:0]       player_x,
    input  logic [12:0]       player_y,
    input  logic [7:0]        player_size,
    output logic [ADDR_W-1:0] coin_rom_addr,
    output logic              is_coin,
    output logic              coin_collect,
    output logic [7:0]        collected_count
);

    localparam int               CNT_W    = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_COINS - 1);
    localparam logic [13:0]      COIN_W14 = 14'(COIN_W);
    localparam logic [13:0]      COIN_H14 = 14'(COIN_H);

    coin_slot_t          r_slots [NUM_COINS];
    coin_state_t         r_state;
    logic [2:0]          r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_collect;
    logic [7:0]          r_count;
    logic [1:0]          r_fsync;
    logic                r_fprev;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_hit_d;
    logic                r_is_coin;

    logic                w_frame_tick;
    logic [NUM_COINS-1:0] w_pix_box;
    logic                w_pix_any;
    logic [12:0]         w_sel_x;
    logic [12:0]         w_sel_y;
    logic [12:0]         w_dx;
    logic [12:0]         w_dy;
    logic [ADDR_W-1:0]   w_pix_off;
    coin_slot_t          w_scan_slot;
    logic                w_scan_box;
    logic                w_collect;
    logic                w_respawn;
    logic [NUM_COINS-1:0] w_act_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync <= '0;
            r_fprev <= 1'b0;
        end else begin
            r_fsync <= {r_fsync[0], frame_clk};
            r_fprev <= r_fsync[1];
        end
    end

    assign w_frame_tick = r_fsync[1] & ~r_fprev;

    for (genvar g = 0; g < NUM_COINS; g++) begin : g_pix
        coin_box_hit u_pix_hit (
            .i_a_x (DrawX),
            .i_a_y (DrawY),
            .i_a_w (14'd1),
            .i_a_h (14'd1),
            .i_b_x (r_slots[g].x),
            .i_b_y (r_slots[g].y),
            .i_b_w (COIN_W14),
            .i_b_h (COIN_H14),
            .o_hit (w_pix_box[g])
        );
    end

    // NOTE: defaults first so no path through a combinational block leaves a latch.
    always_comb begin
        w_pix_any = 1'b0;
        w_sel_x   = '0;
        w_sel_y   = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (w_pix_box[i] && r_slots[i].active) begin
                w_pix_any = 1'b1;
                w_sel_x   = r_slots[i].x;
                w_sel_y   = r_slots[i].y;
            end
        end
    end

    assign w_dx      = DrawX - w_sel_x;
    assign w_dy      = DrawY - w_sel_y;
    assign w_pix_off = ADDR_W'(32'(w_dy) * 32'(COIN_W) + 32'(w_dx));

    always_comb begin
        w_scan_slot = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (3'(i) == r_idx) w_scan_slot = r_slots[i];
        end
    end

    coin_box_hit u_scan_hit (
        .i_a_x (player_x),
        .i_a_y (player_y),
        .i_a_w ({6'd0, player_size}),
        .i_a_h ({6'd0, player_size}),
        .i_b_x (w_scan_slot.x),
        .i_b_y (w_scan_slot.y),
        .i_b_w (COIN_W14),
        .i_b_h (COIN_H14),
        .o_hit (w_scan_box)
    );

    assign w_collect = (r_state == SCAN) && w_scan_slot.active && w_scan_box;
    assign w_respawn = (r_state == WAIT_RESPAWN) && w_frame_tick && (r_cnt == CNT_LAST);

    // Later assignments take priority: a load beats a same-cycle clear.
    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) begin
            w_act_nxt[i] = r_slots[i].active;
            if (w_collect && (3'(i) == r_idx))          w_act_nxt[i] = 1'b0;
            if (w_respawn)                              w_act_nxt[i] = 1'b1;
            if (load_valid && (load_idx == 3'(i)))      w_act_nxt[i] = 1'b1;
        end
    end

    // NOTE: the slot array is a handful of flops, not RAM, so reset clears it to a known world.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_COINS; i++) r_slots[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_COINS; i++) begin
                r_slots[i].active <= w_act_nxt[i];
                if (load_valid && (load_idx == 3'(i))) begin
                    r_slots[i].x <= load_x;
                    r_slots[i].y <= load_y;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_collect <= 1'b0;
            r_count   <= '0;
        end else begin
            r_collect <= w_collect;
            if (w_collect && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
            case (r_state)
                IDLE: begin
                    if (w_frame_tick) begin
                        r_state <= SCAN;
                        r_idx   <= '0;
                    end
                end
                SCAN: begin
                    if (r_idx == LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= (|w_act_nxt) ? IDLE : WAIT_RESPAWN;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                WAIT_RESPAWN: begin
                    if (w_frame_tick) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Hit flag is delayed twice so is_coin lands with the ROM data one stage later.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr    <= '0;
            r_hit_d   <= 1'b0;
            r_is_coin <= 1'b0;
        end else begin
            if (w_pix_any) r_addr <= w_pix_off;
            r_hit_d   <= w_pix_any;
            r_is_coin <= r_hit_d;
        end
    end

    assign coin_rom_addr   = r_addr;
    assign is_coin         = r_is_coin;
    assign coin_collect    = r_collect;
    assign collected_count = r_count;

endmodule

// File: tb/tb_coin_sprite_ctrl.sv
// Bench for coin_sprite_ctrl: directed vector table, hand sequences for pickup,
// respawn, saturation and mid-scan reset, plus random traffic against a slot-list model.
module tb_coin_sprite_ctrl;
    import coin_pkg::*;

    localparam int NC = 4;
    localparam int CW = 16;
    localparam int CH = 16;
    localparam int AW = 8;
    localparam int RF = 3;

    logic          Clk;
    logic          Reset_n;
    logic          frame_clk;
    logic [12:0]   DrawX;
    logic [12:0]   DrawY;
    logic          load_valid;
    logic [2:0]    load_idx;
    logic [12:0]   load_x;
    logic [12:0]   load_y;
    logic [12:0]   player_x;
    logic [12:0]   player_y;
    logic [7:0]    player_size;
    logic [AW-1:0] coin_rom_addr;
    logic          is_coin;
    logic          coin_collect;
    logic [7:0]    collected_count;

    coin_sprite_ctrl #(
        .NUM_COINS      (NC),
        .COIN_W         (CW),
        .COIN_H         (CH),
        .ADDR_W         (AW),
        .RESPAWN_FRAMES (RF)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .frame_clk       (frame_clk),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .load_valid      (load_valid),
        .load_idx        (load_idx),
        .load_x          (load_x),
        .load_y          (load_y),
        .player_x        (player_x),
        .player_y        (player_y),
        .player_size     (player_size),
        .coin_rom_addr   (coin_rom_addr),
        .is_coin         (is_coin),
        .coin_collect    (coin_collect),
        .collected_count (collected_count)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;

    always @(negedge Clk) if (coin_collect === 1'b1) pulse_cnt++;

    // Reference world: a plain list of coins plus a frame-based respawn countdown.
    int m_x [NC];
    int m_y [NC];
    bit m_act [NC];
    int m_count;
    bit m_wait;
    int m_waited;
    int m_last_addr;

    typedef struct {
        int stage;
        int x;
        int y;
        bit hit;
        int addr;
    } pix_vec_t;

    pix_vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_x[i]   = 0;
            m_y[i]   = 0;
            m_act[i] = 1'b0;
        end
        m_count     = 0;
        m_wait      = 1'b0;
        m_waited    = 0;
        m_last_addr = 0;
    endfunction

    function automatic void model_pixel(input int x, input int y, output bit hit, output int off);
        hit = 1'b0;
        off = 0;
        for (int i = 0; i < NC; i++) begin
            if (!hit && m_act[i] && x >= m_x[i] && x < m_x[i] + CW && y >= m_y[i] && y < m_y[i] + CH) begin
                hit = 1'b1;
                off = ((y - m_y[i]) * CW + (x - m_x[i])) % (1 << AW);
            end
        end
    endfunction

    function automatic int model_frame(input int px, input int py, input int ps);
        int  p;
        bit  any;
        p = 0;
        if (m_wait) begin
            m_waited++;
            if (m_waited == RF) begin
                for (int i = 0; i < NC; i++) m_act[i] = 1'b1;
                m_wait = 1'b0;
            end
            return 0;
        end
        for (int i = 0; i < NC; i++) begin
            if (m_act[i] && px < m_x[i] + CW && m_x[i] < px + ps && py < m_y[i] + CH && m_y[i] < py + ps) begin
                m_act[i] = 1'b0;
                p++;
                if (m_count < 255) m_count++;
            end
        end
        any = 1'b0;
        for (int i = 0; i < NC; i++) any |= m_act[i];
        if (!any) begin
            m_wait   = 1'b1;
            m_waited = 0;
        end
        return p;
    endfunction

    task automatic load_slot(input int idx, input int x, input int y);
        @(posedge Clk); #1;
        load_valid = 1'b1;
        load_idx   = 3'(idx);
        load_x     = 13'(x);
        load_y     = 13'(y);
        @(posedge Clk); #1;
        load_valid = 1'b0;
        if (idx < NC) begin
            m_x[idx]   = x;
            m_y[idx]   = y;
            m_act[idx] = 1'b1;
        end
    endtask

    task automatic apply_pixel(input int x, input int y, output logic [31:0] addr, output logic [31:0] isc);
        @(posedge Clk); #1;
        DrawX = 13'(x);
        DrawY = 13'(y);
        @(posedge Clk); #1;
        addr = 32'(coin_rom_addr);
        @(posedge Clk); #1;
        isc = 32'(is_coin);
        DrawX = 13'h1FFF;
        DrawY = 13'h1FFF;
    endtask

    task automatic check_pixel(input int x, input int y, input string tag);
        bit          h;
        int          off;
        int          exp_addr;
        logic [31:0] a;
        logic [31:0] c;
        model_pixel(x, y, h, off);
        exp_addr = h ? off : m_last_addr;
        apply_pixel(x, y, a, c);
        check($sformatf("%s addr (%0d,%0d)", tag, x, y), a, 32'(exp_addr));
        check($sformatf("%s is_coin (%0d,%0d)", tag, x, y), c, 32'(h));
        m_last_addr = exp_addr;
    endtask

    task automatic do_frame(input int px, input int py, input int ps, input string tag);
        int p0;
        int exp_p;
        @(posedge Clk); #1;
        player_x    = 13'(px);
        player_y    = 13'(py);
        player_size = 8'(ps);
        p0          = pulse_cnt;
        frame_clk   = 1'b1;
        repeat (12) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        exp_p = model_frame(px, py, ps);
        check({tag, " pulses"}, 32'(pulse_cnt - p0), 32'(exp_p));
        check({tag, " count"}, 32'(collected_count), 32'(m_count));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] c;
        bit          reloaded;
        bit          seen;
        int          x;
        int          y;
        int          k;
        int          p0;

        vecs[0]  = '{0, 100,  50, 1'b1,   0};
        vecs[1]  = '{0, 115,  65, 1'b1, 255};
        vecs[2]  = '{0, 116,  50, 1'b0, 255};
        vecs[3]  = '{0, 107,  58, 1'b1, 135};
        vecs[4]  = '{0,  99,  50, 1'b0, 135};
        vecs[5]  = '{0, 100,  66, 1'b0, 135};
        vecs[6]  = '{1, 110,  50, 1'b1,  10};
        vecs[7]  = '{1, 116,  50, 1'b1,   8};
        vecs[8]  = '{1, 123,  50, 1'b1,  15};
        vecs[9]  = '{1, 124,  50, 1'b0,  15};
        vecs[10] = '{1, 8191, 10, 1'b1,   6};
        vecs[11] = '{1,   2,  10, 1'b0,   6};
        vecs[12] = '{1, 600, 600, 1'b1,   0};
        vecs[13] = '{1, 115,  51, 1'b1,  31};

        Reset_n     = 1'b0;
        frame_clk   = 1'b0;
        DrawX       = 13'h1FFF;
        DrawY       = 13'h1FFF;
        load_valid  = 1'b0;
        load_idx    = '0;
        load_x      = '0;
        load_y      = '0;
        player_x    = 13'd4000;
        player_y    = 13'd4000;
        player_size = 8'd1;
        model_reset();

        repeat (3) @(posedge Clk);
        #1;
        check("reset addr", 32'(coin_rom_addr), 32'd0);
        check("reset is_coin", 32'(is_coin), 32'd0);
        check("reset collect", 32'(coin_collect), 32'd0);
        check("reset count", 32'(collected_count), 32'd0);
        check("reset state", 32'(dut.r_state), 32'(IDLE));
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed pixel table.
        load_slot(0, 100, 50);
        reloaded = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].stage == 1 && !reloaded) begin
                load_slot(0, 600, 600);
                load_slot(1, 100, 50);
                load_slot(2, 108, 50);
                load_slot(3, 8185, 10);
                reloaded = 1'b1;
            end
            apply_pixel(vecs[i].x, vecs[i].y, a, c);
            check($sformatf("vec%0d addr", i), a, 32'(vecs[i].addr));
            check($sformatf("vec%0d is_coin", i), c, 32'(vecs[i].hit));
            m_last_addr = vecs[i].addr;
        end

        // Pickup: touching boxes do not collect, overlapping ones do exactly once.
        load_slot(0, 200, 200);
        do_frame(184, 184, 16, "touch frame");
        check("touch count const", 32'(collected_count), 32'd0);
        do_frame(190, 190, 16, "pickup frame");
        check("pickup count const", 32'(collected_count), 32'd1);
        check_pixel(200, 200, "picked slot");
        do_frame(190, 190, 16, "second frame");
        check("second count const", 32'(collected_count), 32'd1);

        // Respawn after RF frames once every coin is gone.
        load_slot(0, 300, 300);
        load_slot(1, 320, 300);
        load_slot(2, 340, 300);
        load_slot(3, 360, 300);
        do_frame(300, 300, 200, "collect all");
        check("collect all count const", 32'(collected_count), 32'd5);
        do_frame(3000, 3000, 1, "wait frame1");
        check_pixel(300, 300, "wait1");
        do_frame(3000, 3000, 1, "wait frame2");
        check_pixel(300, 300, "wait2");
        do_frame(3000, 3000, 1, "respawn frame");
        check_pixel(300, 300, "respawned");
        check_pixel(345, 310, "respawned s2");

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, NC - 1));
            case ($urandom_range(0, 2))
                0: load_slot(int'($urandom_range(0, 7)), int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)));
                1: begin
                    x = m_x[k] + int'($urandom_range(0, 23)) - 4;
                    y = m_y[k] + int'($urandom_range(0, 23)) - 4;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                    check_pixel(x, y, "rand pix");
                end
                default: begin
                    x = m_x[k] + int'($urandom_range(0, 40)) - 20;
                    y = m_y[k] + int'($urandom_range(0, 40)) - 20;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                    do_frame(x, y, int'($urandom_range(1, 40)), "rand frame");
                end
            endcase
        end

        // Saturation: three pickups per frame, one coin kept out of reach.
        for (int it = 0; it < 95; it++) begin
            load_slot(0, 400, 400);
            load_slot(1, 420, 400);
            load_slot(2, 440, 400);
            load_slot(3, 1500, 1500);
            do_frame(400, 400, 100, "sat frame");
        end
        check("saturated count const", 32'(collected_count), 32'd255);

        // Asynchronous reset in the middle of a scan.
        load_slot(0, 200, 200);
        @(posedge Clk); #1;
        player_x    = 13'd190;
        player_y    = 13'd190;
        player_size = 8'd16;
        frame_clk   = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge Clk);
            if (coin_collect === 1'b1) seen = 1'b1;
        end
        check("mid-scan pulse seen", 32'(seen), 32'd1);
        #3 Reset_n = 1'b0;
        #1;
        check("async rst addr", 32'(coin_rom_addr), 32'd0);
        check("async rst is_coin", 32'(is_coin), 32'd0);
        check("async rst collect", 32'(coin_collect), 32'd0);
        check("async rst count", 32'(collected_count), 32'd0);
        check("async rst state", 32'(dut.r_state), 32'(IDLE));
        frame_clk = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        p0 = pulse_cnt;
        repeat (30) @(posedge Clk);
        #1;
        check("post-reset pulses", 32'(pulse_cnt - p0), 32'd0);
        check("post-reset count", 32'(collected_count), 32'd0);
        check_pixel(200, 200, "post-reset pix");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
